// File: rtl/apb_uart_csr_if.sv
// APB bus bundle for the UART register block; the master side drives the request and
// the slave side returns read data, ready and the error response.
interface apb_uart_csr_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              P_sel;
    logic              P_enable;
    logic              P_write;
    logic [ADDR_W-1:0] P_address;
    logic [DATA_W-1:0] PW_data;
    logic [DATA_W-1:0] PR_data;
    logic              P_ready;
    logic              P_slverr;

    modport master (
        output P_sel, P_enable, P_write, P_address, PW_data,
        input  PR_data, P_ready, P_slverr
    );

    modport slave (
        input  P_sel, P_enable, P_write, P_address, PW_data,
        output PR_data, P_ready, P_slverr
    );
endinterface

// File: rtl/apb_uart_csr.sv
// APB register block for the UART: CTRL, BAUD, W1C STATUS and byte FIFOs to the shifters.
// Define UART_APB_SLVERR_EN to return P_slverr on illegal or rejected accesses.
module apb_uart_csr #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] BAUD_RST    = 16'd163
) (
    input  logic                 P_clk,
    input  logic                 P_resetn,
    apb_uart_csr_if.slave        apb,
    output logic                 uart_en,
    output logic [15:0]          baud_div,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] SEL_CTRL   = 3'd0;
    localparam logic [2:0] SEL_BAUD   = 3'd1;
    localparam logic [2:0] SEL_STATUS = 3'd2;
    localparam logic [2:0] SEL_TXDATA = 3'd3;
    localparam logic [2:0] SEL_RXDATA = 3'd4;

    logic [2:0]       ctrl;
    logic [15:0]      baud;
    logic             rx_overrun;
    logic [2:0]       wait_cnt;
    logic             access;
    logic             ready_int;
    logic             commit;
    logic             wr_commit;
    logic             rd_commit;
    logic [2:0]       reg_sel;
    logic [31:0]      wdata;
    logic [31:0]      rdata;

    logic [7:0]       tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_rd;
    logic [PTR_W-1:0] tx_wr;
    logic [CNT_W-1:0] tx_cnt;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_pop;
    logic             tx_push;

    logic [7:0]       rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_rd;
    logic [PTR_W-1:0] rx_wr;
    logic [CNT_W-1:0] rx_cnt;
    logic             rx_full;
    logic             rx_empty;
    logic             rx_pop;
    logic             rx_push_req;
    logic             rx_push;

    logic             unused_ok;

    assign reg_sel   = apb.P_address[4:2];
    assign wdata     = 32'(apb.PW_data);
    assign access    = apb.P_sel && apb.P_enable;
    assign ready_int = access && (wait_cnt == 3'(WAIT_STATES));
    assign commit    = P_resetn && ready_int;
    assign wr_commit = commit && apb.P_write;
    assign rd_commit = commit && !apb.P_write;
    assign apb.P_ready = commit;

    assign unused_ok = ^{apb.P_address[ADDR_W-1:5], apb.P_address[1:0], wdata[31:16]};

    always_ff @(posedge P_clk) begin
        if (!P_resetn) begin
            wait_cnt <= '0;
        end else if (!access) begin
            wait_cnt <= '0;
        end else if (!ready_int) begin
            wait_cnt <= wait_cnt + 3'd1;
        end
    end

    always_ff @(posedge P_clk) begin
        if (!P_resetn) begin
            ctrl <= '0;
            baud <= BAUD_RST;
        end else if (wr_commit) begin
            if (reg_sel == SEL_CTRL) ctrl <= wdata[2:0];
            if (reg_sel == SEL_BAUD) baud <= wdata[15:0];
        end
    end

    assign uart_en  = ctrl[0];
    assign baud_div = baud;

    assign tx_full  = (tx_cnt == CNT_W'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign tx_valid = P_resetn && uart_en && !tx_empty;
    assign tx_data  = tx_mem[tx_rd];
    assign tx_pop   = tx_valid && tx_ready;
    // A full FIFO can still accept a byte when the shifter frees a slot on the same edge.
    assign tx_push  = wr_commit && (reg_sel == SEL_TXDATA) && (!tx_full || tx_pop);

    always_ff @(posedge P_clk) begin
        if (!P_resetn) begin
            tx_rd  <= '0;
            tx_wr  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + PTR_W'(1);
            if (tx_pop)  tx_rd <= tx_rd + PTR_W'(1);
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CNT_W'(1);
            else if (tx_pop && !tx_push) tx_cnt <= tx_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge P_clk) begin
        if (tx_push) tx_mem[tx_wr] <= wdata[7:0];
    end

    assign rx_full     = (rx_cnt == CNT_W'(FIFO_DEPTH));
    assign rx_empty    = (rx_cnt == '0);
    assign rx_pop      = rd_commit && (reg_sel == SEL_RXDATA) && !rx_empty;
    assign rx_push_req = P_resetn && rx_valid && uart_en;
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);

    always_ff @(posedge P_clk) begin
        if (!P_resetn) begin
            rx_rd  <= '0;
            rx_wr  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + PTR_W'(1);
            if (rx_pop)  rx_rd <= rx_rd + PTR_W'(1);
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CNT_W'(1);
            else if (rx_pop && !rx_push) rx_cnt <= rx_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge P_clk) begin
        if (rx_push) rx_mem[rx_wr] <= rx_data;
    end

    // A dropped byte wins over a simultaneous W1C so no overrun event is lost.
    always_ff @(posedge P_clk) begin
        if (!P_resetn) begin
            rx_overrun <= 1'b0;
        end else if (rx_push_req && !rx_push) begin
            rx_overrun <= 1'b1;
        end else if (wr_commit && (reg_sel == SEL_STATUS) && wdata[4]) begin
            rx_overrun <= 1'b0;
        end
    end

    assign irq = P_resetn && ((ctrl[1] && tx_empty) || (ctrl[2] && !rx_empty) || rx_overrun);

    always_comb begin
        rdata = '0;
        case (reg_sel)
            SEL_CTRL:   rdata = {29'd0, ctrl};
            SEL_BAUD:   rdata = {16'd0, baud};
            SEL_STATUS: rdata = {27'd0, rx_overrun, rx_empty, rx_full, tx_empty, tx_full};
            SEL_RXDATA: rdata = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd]};
            default:    rdata = '0;
        endcase
    end

    assign apb.PR_data = rd_commit ? rdata[DATA_W-1:0] : '0;

`ifdef UART_APB_SLVERR_EN
    logic slverr;

    always_comb begin
        slverr = 1'b0;
        if (commit) begin
            case (reg_sel)
                SEL_STATUS: slverr = apb.P_write && ((wdata[31:5] != '0) || (wdata[3:0] != '0));
                SEL_TXDATA: slverr = !apb.P_write || !(!tx_full || tx_pop);
                SEL_RXDATA: slverr = apb.P_write || rx_empty;
                SEL_CTRL, SEL_BAUD: slverr = 1'b0;
                default:    slverr = 1'b1;
            endcase
        end
    end

    assign apb.P_slverr = slverr;
`else
    assign apb.P_slverr = 1'b0;
`endif
endmodule
